// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request channel, redirect input and decode output.
// The fetch unit connects through the master modport and its environment through the slave modport.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            pc_load_in;
  logic [XLEN-1:0] pc_load_addr_in;
  logic            ins_mem_valid_out;
  logic [XLEN-1:0] ins_mem_addr_out;
  logic            ins_mem_ready_in;
  logic [XLEN-1:0] ins_mem_data_in;
  logic            fetch_valid_out;
  logic [XLEN-1:0] fetch_ins_out;
  logic [XLEN-1:0] fetch_pc_out;
  logic            decode_ready_in;

  modport master (
    input  pc_load_in,
    input  pc_load_addr_in,
    output ins_mem_valid_out,
    output ins_mem_addr_out,
    input  ins_mem_ready_in,
    input  ins_mem_data_in,
    output fetch_valid_out,
    output fetch_ins_out,
    output fetch_pc_out,
    input  decode_ready_in
  );

  modport slave (
    output pc_load_in,
    output pc_load_addr_in,
    input  ins_mem_valid_out,
    input  ins_mem_addr_out,
    output ins_mem_ready_in,
    output ins_mem_data_in,
    input  fetch_valid_out,
    input  fetch_ins_out,
    input  fetch_pc_out,
    output decode_ready_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, 2-entry {pc, ins} queue to decode, and a small FSM that
// throttles memory requests when the queue is full or a redirect is in progress.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic         clock_in,
  input  logic         reset_in,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] qpc_q  [2];
  logic [XLEN-1:0] qpc_d  [2];
  logic [XLEN-1:0] qins_q [2];
  logic [XLEN-1:0] qins_d [2];

  logic redirect;
  logic req;
  logic xfer;
  logic pop;
  logic slot;

  assign redirect = bus.pc_load_in;
  assign xfer     = req & bus.ins_mem_ready_in;
  // A redirect discards the queue, so a simultaneous decode handshake must not consume anything.
  assign pop      = (count_q != 2'd0) & bus.decode_ready_in & ~redirect;
  assign slot     = count_q[0] & ~pop;

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH, S_FULL: begin
        if (redirect) begin
          state_d = S_FETCH;
        end else if (count_d == 2'd2) begin
          state_d = S_FULL;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    req = (state_q == S_FETCH) && (count_q < 2'd2) && !redirect;
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    qpc_d   = qpc_q;
    qins_d  = qins_q;
    if (redirect) begin
      pc_d      = bus.pc_load_addr_in & ~XLEN'(3);
      count_d   = 2'd0;
      qpc_d[0]  = '0;
      qpc_d[1]  = '0;
      qins_d[0] = '0;
      qins_d[1] = '0;
    end else begin
      if (pop) begin
        qpc_d[0]  = qpc_q[1];
        qins_d[0] = qins_q[1];
      end
      // Requests are only issued below count 2, so the push slot is the first free one after any pop.
      if (xfer) begin
        qpc_d[slot]  = pc_q;
        qins_d[slot] = bus.ins_mem_data_in;
        pc_d         = pc_q + XLEN'(4);
      end
      count_d = count_q + {1'b0, xfer} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      pc_q    <= RESET_VECTOR;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        qpc_q[i]  <= '0;
        qins_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      for (int i = 0; i < 2; i++) begin
        qpc_q[i]  <= qpc_d[i];
        qins_q[i] <= qins_d[i];
      end
    end
  end

  assign bus.ins_mem_valid_out = req;
  assign bus.ins_mem_addr_out  = pc_q;
  assign bus.fetch_valid_out   = (count_q != 2'd0);
  assign bus.fetch_ins_out     = (count_q != 2'd0) ? qins_q[0] : '0;
  assign bus.fetch_pc_out      = (count_q != 2'd0) ? qpc_q[0]  : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle, plus directed
// scenarios with literal expectations for reset, stalls, full queue, redirects and wrap.
module tb_fetch_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN(XLEN),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clock_in(clk),
    .reset_in(rst_n),
    .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus.ins_mem_data_in = mem_word(bus.ins_mem_addr_out);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC plus a queue of fetched PCs (instruction = mem_word(pc)).
  bit          known   = 1'b0;
  bit          started = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] mq[$];

  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_fpc;
    logic [31:0] e_ins;
    if (known) begin
      e_valid = started && (mq.size() < 2) && !bus.pc_load_in;
      e_fpc   = (mq.size() != 0) ? mq[0] : 32'h0;
      e_ins   = (mq.size() != 0) ? mem_word(mq[0]) : 32'h0;
      chk("mdl_mem_valid",   32'(bus.ins_mem_valid_out), 32'(e_valid));
      chk("mdl_mem_addr",    bus.ins_mem_addr_out,       m_pc);
      chk("mdl_fetch_valid", 32'(bus.fetch_valid_out),   32'(mq.size() != 0));
      chk("mdl_fetch_pc",    bus.fetch_pc_out,           e_fpc);
      chk("mdl_fetch_ins",   bus.fetch_ins_out,          e_ins);
    end else begin
      e_valid = 1'b0;
    end
    if (!rst_n) begin
      known   = 1'b1;
      started = 1'b0;
      m_pc    = 32'h0;
      mq.delete();
    end else if (known) begin
      if (bus.pc_load_in) begin
        mq.delete();
        m_pc = bus.pc_load_addr_in & 32'hFFFF_FFFC;
        $display("redirect to %h", m_pc);
      end else begin
        if (mq.size() != 0 && bus.decode_ready_in) begin
          $display("pop pc=%h ins=%h", mq[0], mem_word(mq[0]));
          void'(mq.pop_front());
        end
        if (e_valid && bus.ins_mem_ready_in) begin
          mq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      started = 1'b1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_load_in       = 1'b0;
    bus.pc_load_addr_in  = 32'h0;
    bus.ins_mem_ready_in = 1'b1;
    bus.decode_ready_in  = 1'b1;

    // Reset release with everything ready: streaming fetch
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    #2;
    chk("rst_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    chk("rst_mem_addr",  bus.ins_mem_addr_out,       32'h0);
    chk("rst_fvalid",    32'(bus.fetch_valid_out),   32'd0);
    chk("rst_fins",      bus.fetch_ins_out,          32'h0);
    chk("rst_fpc",       bus.fetch_pc_out,           32'h0);
    cyc(); #2;
    chk("c1_mem_valid", 32'(bus.ins_mem_valid_out), 32'd1);
    chk("c1_mem_addr",  bus.ins_mem_addr_out,       32'h0);
    chk("c1_fvalid",    32'(bus.fetch_valid_out),   32'd0);
    cyc(); #2;
    chk("c2_fvalid", 32'(bus.fetch_valid_out), 32'd1);
    chk("c2_fpc",    bus.fetch_pc_out,         32'h0);
    chk("c2_fins",   bus.fetch_ins_out,        32'h5A5A_C3C3);
    cyc(); #2;
    chk("c3_fpc", bus.fetch_pc_out, 32'h4);
    cyc(2); #2;
    chk("c5_fpc", bus.fetch_pc_out, 32'hC);

    // Decode stalled from reset: queue fills, then one pop reopens fetch
    bus.decode_ready_in = 1'b0;
    do_reset();
    cyc(3); #2;
    chk("full_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    chk("full_mem_addr",  bus.ins_mem_addr_out,       32'h8);
    chk("full_fpc",       bus.fetch_pc_out,           32'h0);
    cyc();
    bus.decode_ready_in = 1'b1;
    #2;
    chk("full_pop_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    cyc(); #2;
    chk("after_pop_mem_valid", 32'(bus.ins_mem_valid_out), 32'd1);
    chk("after_pop_mem_addr",  bus.ins_mem_addr_out,       32'h8);
    chk("after_pop_fpc",       bus.fetch_pc_out,           32'h4);

    // Memory wait of three cycles at 0x10
    cyc(2);
    bus.ins_mem_ready_in = 1'b0;
    #2;
    chk("wait0_mem_valid", 32'(bus.ins_mem_valid_out), 32'd1);
    chk("wait0_mem_addr",  bus.ins_mem_addr_out,       32'h10);
    cyc(); #2;
    chk("wait1_mem_addr", bus.ins_mem_addr_out,     32'h10);
    chk("wait1_fvalid",   32'(bus.fetch_valid_out), 32'd0);
    cyc(); #2;
    chk("wait2_mem_valid", 32'(bus.ins_mem_valid_out), 32'd1);
    chk("wait2_mem_addr",  bus.ins_mem_addr_out,       32'h10);
    cyc();
    bus.ins_mem_ready_in = 1'b1;
    #2;
    chk("wait_end_fvalid", 32'(bus.fetch_valid_out), 32'd0);
    cyc(); #2;
    chk("wait_push_fpc",   bus.fetch_pc_out,     32'h10);
    chk("wait_next_addr",  bus.ins_mem_addr_out, 32'h14);

    // Full queue {0x20,0x24} flushed by redirect to 0x103
    bus.decode_ready_in = 1'b0;
    do_reset();
    cyc();
    bus.pc_load_in      = 1'b1;
    bus.pc_load_addr_in = 32'h20;
    #2;
    chk("rd_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    cyc();
    bus.pc_load_in = 1'b0;
    #2;
    chk("rd_addr20", bus.ins_mem_addr_out, 32'h20);
    cyc(2);
    bus.pc_load_in      = 1'b1;
    bus.pc_load_addr_in = 32'h103;
    bus.decode_ready_in = 1'b1;
    #2;
    chk("q_full_fpc", bus.fetch_pc_out, 32'h20);
    cyc();
    bus.pc_load_in = 1'b0;
    #2;
    chk("flush_fvalid",    32'(bus.fetch_valid_out),   32'd0);
    chk("flush_mem_addr",  bus.ins_mem_addr_out,       32'h100);
    chk("flush_mem_valid", 32'(bus.ins_mem_valid_out), 32'd1);
    cyc(); #2;
    chk("flush_first_fpc", bus.fetch_pc_out,  32'h100);
    chk("flush_first_ins", bus.fetch_ins_out, 32'h5A5A_C3C2);

    // Back-to-back redirects, last one wins, then wrap past the top of memory
    bus.pc_load_in      = 1'b1;
    bus.pc_load_addr_in = 32'h500;
    cyc();
    bus.pc_load_addr_in = 32'hFFFF_FFFE;
    #2;
    chk("b2b_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    cyc();
    bus.pc_load_in = 1'b0;
    #2;
    chk("wrap_addr_top", bus.ins_mem_addr_out, 32'hFFFF_FFFC);
    cyc(); #2;
    chk("wrap_fpc_top", bus.fetch_pc_out,     32'hFFFF_FFFC);
    chk("wrap_addr0",   bus.ins_mem_addr_out, 32'h0);
    cyc(); #2;
    chk("wrap_fpc0", bus.fetch_pc_out, 32'h0);

    // One-cycle reset with a full queue and a simultaneous redirect
    bus.decode_ready_in = 1'b0;
    cyc(3); #2;
    chk("pre_rst_fvalid",    32'(bus.fetch_valid_out),   32'd1);
    chk("pre_rst_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    rst_n               = 1'b0;
    bus.pc_load_in      = 1'b1;
    bus.pc_load_addr_in = 32'h40;
    cyc();
    rst_n          = 1'b1;
    bus.pc_load_in = 1'b0;
    #2;
    chk("mid_rst_mem_valid", 32'(bus.ins_mem_valid_out), 32'd0);
    chk("mid_rst_mem_addr",  bus.ins_mem_addr_out,       32'h0);
    chk("mid_rst_fvalid",    32'(bus.fetch_valid_out),   32'd0);
    chk("mid_rst_fins",      bus.fetch_ins_out,          32'h0);
    chk("mid_rst_fpc",       bus.fetch_pc_out,           32'h0);
    cyc(); #2;
    chk("restart_mem_valid", 32'(bus.ins_mem_valid_out), 32'd1);
    chk("restart_mem_addr",  bus.ins_mem_addr_out,       32'h0);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      bus.ins_mem_ready_in = ($urandom_range(0, 3) != 0);
      bus.decode_ready_in  = ($urandom_range(0, 2) != 0);
      bus.pc_load_in       = ($urandom_range(0, 15) == 0);
      bus.pc_load_addr_in  = $urandom;
      cyc();
    end
    bus.pc_load_in = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
